scroll_window_gen: RTL and testbench

//  Upstream feeder for the 8-digit SSD decoder bank: holds a message of up to MSG_MAX char codes,

---
 rtl/scroll_window_gen_pkg.sv | 26 ++
 rtl/scroll_window_gen_prescaler.sv | 30 +++
 rtl/scroll_window_gen.sv | 115 +++++++++++
 tb/tb_scroll_window_gen.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scroll_window_gen_pkg.sv
// Shared character codes, default message and timing constants for the scrolling
// window generator and its prescaler.
package scroll_window_gen_pkg;

    localparam int CH_H     = 0;
    localparam int CH_E     = 1;
    localparam int CH_L     = 2;
    localparam int CH_O     = 3;
    localparam int CH_BLANK = 4;

    localparam int DEFAULT_BOUND = 18000000;
    localparam int DEFAULT_LEN   = 8;
    localparam int WINDOW        = 8;

    // Power-up message "HELLO" followed by blanks; every slot past the text is blank.
    function automatic int default_char(input int idx);
        case (idx)
            0:       return CH_H;
            1:       return CH_E;
            2, 3:    return CH_L;
            4:       return CH_O;
            default: return CH_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/scroll_window_gen_prescaler.sv
// Free-running scroll prescaler: emits a registered one-cycle tick every BOUND
// unpaused clock cycles. Pause freezes the count without losing progress.
module scroll_window_gen_prescaler #(
    parameter int BOUND = 18000000,
    parameter int CNT_W = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic pause,
    output logic tick
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (pause) begin
            tick <= 1'b0;
        end else if (cnt == CNT_W'(BOUND - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/scroll_window_gen.sv
// Message store plus scroll offset, presenting an 8-character window to the
// SSD decoder bank (slot 7 = HEX7, leftmost). Message wraps at its current length.
module scroll_window_gen
    import scroll_window_gen_pkg::*;
#(
    parameter int MSG_MAX = 16,
    parameter int CHAR_W  = 3,
    parameter int BOUND   = DEFAULT_BOUND,
    parameter int CNT_W   = 32
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic                       dir,
    input  logic                       pause,
    input  logic                       clr,
    input  logic                       wr_stb,
    input  logic [CHAR_W-1:0]          wr_char,
    output logic [WINDOW*CHAR_W-1:0]   char_out,
    output logic [$clog2(MSG_MAX):0]   msg_len,
    output logic                       full,
    output logic                       tick
);

    localparam int IDX_W = $clog2(MSG_MAX);
    localparam int LEN_W = IDX_W + 1;

    logic [CHAR_W-1:0]         mem [MSG_MAX];
    logic [LEN_W-1:0]          len;
    logic [IDX_W-1:0]          offset;
    logic [IDX_W-1:0]          last_idx;
    logic [IDX_W-1:0]          win_idx;
    logic                      dir_meta;
    logic                      dir_s;
    logic                      step;
    logic                      empty;
    logic [WINDOW*CHAR_W-1:0]  window;

    scroll_window_gen_prescaler #(
        .BOUND (BOUND),
        .CNT_W (CNT_W)
    ) u_scroll_prescaler (
        .clk   (CLOCK_50),
        .rst   (reset),
        .pause (pause),
        .tick  (tick)
    );

    // The switch is asynchronous; both flops come out of reset as "shift left".
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            dir_meta <= 1'b1;
            dir_s    <= 1'b1;
        end else begin
            dir_meta <= dir;
            dir_s    <= dir_meta;
        end
    end

    assign empty    = (len == '0);
    assign full     = (len == LEN_W'(MSG_MAX));
    assign msg_len  = len;
    assign step     = tick & ~pause;
    // At len == MSG_MAX the low bits are zero, so this still wraps to MSG_MAX-1.
    assign last_idx = len[IDX_W-1:0] - IDX_W'(1);

    // clr beats a same-cycle write; a step and a write may coincide and the step sees the old len.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MSG_MAX; i++) begin
                mem[i] <= CHAR_W'(default_char(i));
            end
            len    <= LEN_W'(DEFAULT_LEN);
            offset <= '0;
        end else if (clr) begin
            len    <= '0;
            offset <= '0;
        end else begin
            if (wr_stb && !full) begin
                mem[len[IDX_W-1:0]] <= wr_char;
                len                 <= len + LEN_W'(1);
            end
            if (step && !empty) begin
                if (dir_s) begin
                    offset <= (offset == last_idx) ? '0 : offset + IDX_W'(1);
                end else begin
                    offset <= (offset == '0) ? last_idx : offset - IDX_W'(1);
                end
            end
        end
    end

    always_comb begin
        window  = '0;
        win_idx = offset;
        for (int k = 0; k < WINDOW; k++) begin
            if (empty) begin
                window[(WINDOW-1-k)*CHAR_W +: CHAR_W] = CHAR_W'(CH_BLANK);
            end else begin
                window[(WINDOW-1-k)*CHAR_W +: CHAR_W] = mem[win_idx];
            end
            win_idx = (win_idx == last_idx) ? '0 : win_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < WINDOW; k++) begin
                char_out[(WINDOW-1-k)*CHAR_W +: CHAR_W] <= CHAR_W'(default_char(k));
            end
        end else begin
            char_out <= window;
        end
    end

endmodule

// File: tb/tb_scroll_window_gen.sv
// Directed and randomized bench for scroll_window_gen with a queue-based message
// model; scroll period shortened to 4 cycles.
module tb_scroll_window_gen;

    localparam int CW = 3;
    localparam int MM = 16;

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic          dir;
    logic          pause;
    logic          clr;
    logic          wr_stb;
    logic [CW-1:0] wr_char;
    logic [23:0]   char_out;
    logic [4:0]    msg_len;
    logic          full;
    logic          tick;

    int checks   = 0;
    int failures = 0;

    logic [CW-1:0] m_msg[$];
    int            m_off;
    int            m_cnt;
    logic          m_tick;
    logic          m_d1;
    logic          m_d2;
    logic [23:0]   m_win;

    logic [23:0] hello_win;
    logic [23:0] left1_win;
    logic [23:0] right1_win;
    logic [23:0] ho_win;
    logic [23:0] oh_win;
    logic [23:0] blank_win;

    always #5 CLOCK_50 = ~CLOCK_50;

    scroll_window_gen #(
        .MSG_MAX (MM),
        .CHAR_W  (CW),
        .BOUND   (4),
        .CNT_W   (8)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .dir      (dir),
        .pause    (pause),
        .clr      (clr),
        .wr_stb   (wr_stb),
        .wr_char  (wr_char),
        .char_out (char_out),
        .msg_len  (msg_len),
        .full     (full),
        .tick     (tick)
    );

    // Slot 7 shows message[offset], slot 6 message[offset+1], ... modulo length.
    function automatic logic [23:0] exp_window();
        logic [23:0] w;
        int n;
        n = m_msg.size();
        w = '0;
        for (int k = 0; k < 8; k++) begin
            if (n == 0) w[(7-k)*CW +: CW] = 3'd4;
            else        w[(7-k)*CW +: CW] = m_msg[(m_off + k) % n];
        end
        return w;
    endfunction

    task automatic model_reset();
        m_msg  = {3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
        m_off  = 0;
        m_cnt  = 0;
        m_tick = 1'b0;
        m_d1   = 1'b1;
        m_d2   = 1'b1;
        m_win  = exp_window();
    endtask

    // Advance the model across one rising edge using the inputs held during the cycle.
    task automatic model_edge();
        logic [23:0] nw;
        int n;
        nw = exp_window();
        n  = m_msg.size();
        if (m_tick && !pause && n > 0) begin
            m_off = m_d2 ? (m_off + 1) % n : (m_off + n - 1) % n;
        end
        if (clr) begin
            m_msg.delete();
            m_off = 0;
        end else if (wr_stb && n < MM) begin
            m_msg.push_back(wr_char);
        end
        if (pause) begin
            m_tick = 1'b0;
        end else if (m_cnt == 3) begin
            m_cnt  = 0;
            m_tick = 1'b1;
        end else begin
            m_cnt  = m_cnt + 1;
            m_tick = 1'b0;
        end
        m_d2  = m_d1;
        m_d1  = dir;
        m_win = nw;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("char_out", {8'd0, char_out}, {8'd0, m_win});
        check("msg_len", {27'd0, msg_len}, 32'(m_msg.size()));
        check("full", {31'd0, full}, {31'd0, m_msg.size() == MM});
        check("tick", {31'd0, tick}, {31'd0, m_tick});
    endtask

    task automatic cycle();
        @(posedge CLOCK_50);
        model_edge();
        @(negedge CLOCK_50);
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic write_char(input logic [CW-1:0] c);
        wr_stb  = 1'b1;
        wr_char = c;
        cycle();
        wr_stb  = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_char_out"}, {8'd0, char_out}, {8'd0, hello_win});
        check({tag, "_msg_len"}, {27'd0, msg_len}, 32'd8);
        check({tag, "_full"}, {31'd0, full}, 32'd0);
        check({tag, "_tick"}, {31'd0, tick}, 32'd0);
    endtask

    task automatic apply_reset(input logic dir_val);
        reset = 1'b1;
        dir   = dir_val;
        model_reset();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check_reset_values("reset");
        reset = 1'b0;
    endtask

    initial begin
        hello_win  = {3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
        left1_win  = {3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd0};
        right1_win = {3'd4, 3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4};
        ho_win     = {3'd0, 3'd3, 3'd0, 3'd3, 3'd0, 3'd3, 3'd0, 3'd3};
        oh_win     = {3'd3, 3'd0, 3'd3, 3'd0, 3'd3, 3'd0, 3'd3, 3'd0};
        blank_win  = {8{3'd4}};

        reset   = 1'b1;
        dir     = 1'b1;
        pause   = 1'b0;
        clr     = 1'b0;
        wr_stb  = 1'b0;
        wr_char = '0;
        @(negedge CLOCK_50);

        // Left scroll from reset: first tick after 4 cycles, window moves one cycle later.
        apply_reset(1'b1);
        run(6);
        check("left_first_step", {8'd0, char_out}, {8'd0, left1_win});
        run(10);

        // Right scroll: one step then seven more wraps back to the start.
        apply_reset(1'b0);
        run(6);
        check("right_first_step", {8'd0, char_out}, {8'd0, right1_win});
        run(28);
        check("right_wrap_home", {8'd0, char_out}, {8'd0, hello_win});

        // Pause mid-count, then resume.
        dir = 1'b1;
        run(2);
        pause = 1'b1;
        run(20);
        pause = 1'b0;
        run(8);

        // Two-character message repeats across the window.
        pulse_clr();
        write_char(3'd0);
        write_char(3'd3);
        for (int i = 0; i < 8 && !m_tick; i++) cycle();
        run(1);
        check("two_char_len", {27'd0, msg_len}, 32'd2);
        check("two_char_win", {8'd0, char_out}, {8'd0, ho_win});
        run(1);
        check("two_char_step", {8'd0, char_out}, {8'd0, oh_win});
        run(4);

        // Fill past capacity, then clr colliding with a write.
        pulse_clr();
        for (int i = 0; i < 17; i++) write_char(CW'($urandom_range(0, 7)));
        check("filled_len", {27'd0, msg_len}, 32'd16);
        check("filled_full", {31'd0, full}, 32'd1);
        run(5);
        clr     = 1'b1;
        wr_stb  = 1'b1;
        wr_char = 3'd1;
        cycle();
        clr    = 1'b0;
        wr_stb = 1'b0;
        run(1);
        check("clr_wins_len", {27'd0, msg_len}, 32'd0);
        check("clr_wins_win", {8'd0, char_out}, {8'd0, blank_win});
        run(6);

        // Randomized traffic.
        apply_reset(1'b1);
        for (int i = 0; i < 400; i++) begin
            pause   = ($urandom_range(0, 9) == 0);
            clr     = ($urandom_range(0, 39) == 0);
            wr_stb  = ($urandom_range(0, 2) == 0);
            wr_char = CW'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) dir = ~dir;
            cycle();
        end
        pause  = 1'b0;
        clr    = 1'b0;
        wr_stb = 1'b0;

        // Reset asserted during a tick cycle with a write pending.
        for (int i = 0; i < 8 && !m_tick; i++) cycle();
        check("tick_before_reset", {31'd0, tick}, 32'd1);
        wr_stb  = 1'b1;
        wr_char = 3'd2;
        reset   = 1'b1;
        #1;
        check_reset_values("async_tick");
        model_reset();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check_reset_values("held_tick");
        wr_stb = 1'b0;
        reset  = 1'b0;
        run(6);

        // Reset asserted during a write into a short message.
        pulse_clr();
        write_char(3'd3);
        wr_stb  = 1'b1;
        wr_char = 3'd0;
        reset   = 1'b1;
        #1;
        check_reset_values("async_write");
        model_reset();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check_reset_values("held_write");
        wr_stb = 1'b0;
        reset  = 1'b0;
        run(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
